// File: rtl/twobit_pkg.sv
// Shared definitions for the two-bit program sequencer.
// Contents: opcode encodings, FSM state encoding and program counter width.
package twobit_pkg;

  localparam int unsigned PC_WIDTH = 2;

  // Instruction set; 2'b11 is reserved and executes as a NOP.
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_OPERAND = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/twobit_seq_ctrl_acc_inc.sv
// Combinational accumulator incrementer.
// Ports:
//   a   - value to increment (ACC_WIDTH bits)
//   sum - {carry, a + 1} (ACC_WIDTH + 1 bits)
module acc_inc #(
  parameter int unsigned ACC_WIDTH = 4
) (
  input  logic [ACC_WIDTH-1:0] a,
  output logic [ACC_WIDTH:0]   sum
);

  always_comb begin
    sum = {1'b0, a} + (ACC_WIDTH + 1)'(1);
  end

endmodule

// File: rtl/twobit_seq_ctrl.sv
// Fetch/execute sequencer for a 4-word x 2-bit combinational program ROM.
// Executes INC / JNO / HLT on an internal accumulator with an overflow flag.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   en      - advance enable; all registers hold while low
//   rom_msb - ROM word bit 1
//   rom_lsb - ROM word bit 0
//   sel1    - ROM address bit 1 (pc[1])
//   sel2    - ROM address bit 0 (pc[0])
//   acc     - accumulator value
//   ovf     - carry out of the most recent INC
//   halted  - high while in the HALT state
module twobit_seq_ctrl
  import twobit_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rom_msb,
  input  logic                 rom_lsb,
  output logic                 sel1,
  output logic                 sel2,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 halted
);

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [1:0]            ir_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  ovf_q;
  logic                  halted_q;

  logic [1:0]            rom_word;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [ACC_WIDTH:0]    inc_sum;

  assign rom_word = {rom_msb, rom_lsb};
  // Natural wrap of the 2-bit counter gives 3 -> 0.
  assign pc_inc   = pc_q + PC_WIDTH'(1);

  acc_inc #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc_inc (
    .a  (acc_q),
    .sum(inc_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= 2'b00;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        ST_FETCH: begin
          ir_q    <= rom_word;
          pc_q    <= pc_inc;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (ir_q)
            OP_INC: begin
              acc_q   <= inc_sum[ACC_WIDTH-1:0];
              ovf_q   <= inc_sum[ACC_WIDTH];
              state_q <= ST_FETCH;
            end
            // pc already points at the operand word.
            OP_JNO: state_q <= ST_OPERAND;
            OP_HLT: begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
            default: state_q <= ST_FETCH;
          endcase
        end
        ST_OPERAND: begin
          // Jump when no overflow, otherwise step over the operand word.
          pc_q    <= ovf_q ? pc_inc : rom_word;
          state_q <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign sel1   = pc_q[1];
  assign sel2   = pc_q[0];
  assign acc    = acc_q;
  assign ovf    = ovf_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_twobit_seq_ctrl.sv
module tb_twobit_seq_ctrl;
  import twobit_pkg::*;

  typedef struct {
    int         edge_no;
    logic [3:0] acc;
    logic       ovf;
  } halt_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] acc;
    logic       ovf;
    logic       halted;
  } trace_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic [1:0] rom [4];

  logic       sel1_4, sel2_4, ovf4, halted4, rom_msb4, rom_lsb4;
  logic [3:0] acc4;
  logic       sel1_2, sel2_2, ovf2, halted2, rom_msb2, rom_lsb2;
  logic [1:0] acc2;

  assign {rom_msb4, rom_lsb4} = rom[{sel1_4, sel2_4}];
  assign {rom_msb2, rom_lsb2} = rom[{sel1_2, sel2_2}];

  twobit_seq_ctrl #(.ACC_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .rom_msb(rom_msb4), .rom_lsb(rom_lsb4),
    .sel1(sel1_4), .sel2(sel2_4), .acc(acc4), .ovf(ovf4), .halted(halted4)
  );

  twobit_seq_ctrl #(.ACC_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .rom_msb(rom_msb2), .rom_lsb(rom_lsb2),
    .sel1(sel1_2), .sel2(sel2_2), .acc(acc2), .ovf(ovf2), .halted(halted2)
  );

  always #5 clk = ~clk;

  // Edge number relative to the last reset release; the edge with reset high is edge 0.
  int edge_cnt = 0;
  always @(posedge clk) begin
    if (reset) edge_cnt = 0;
    else       edge_cnt = edge_cnt + 1;
  end

  halt_t  hq4[$];
  halt_t  hq2[$];
  trace_t tq[$];
  trace_t sq[$];
  event   snap_ev;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor: all comparisons happen here.
  initial begin : monitor
    trace_t t;
    halt_t  h;
    logic   h4_prev;
    logic   h2_prev;
    h4_prev = 1'b0;
    h2_prev = 1'b0;
    forever begin
      @(negedge clk or snap_ev);
      if (sq.size() != 0) begin
        t = sq.pop_front();
        n_checks++;
        if ({sel1_4, sel2_4, acc4, ovf4, halted4} !== {t.sel, t.acc, t.ovf, t.halted}) begin
          n_fail++;
          $display("FAIL snap_w4: got sel=%0d acc=%0d ovf=%b halted=%b, expected sel=%0d acc=%0d ovf=%b halted=%b",
                   {sel1_4, sel2_4}, acc4, ovf4, halted4, t.sel, t.acc, t.ovf, t.halted);
        end
        n_checks++;
        if ({sel1_2, sel2_2, 2'b00, acc2, ovf2, halted2} !== {t.sel, t.acc, t.ovf, t.halted}) begin
          n_fail++;
          $display("FAIL snap_w2: got sel=%0d acc=%0d ovf=%b halted=%b, expected sel=%0d acc=%0d ovf=%b halted=%b",
                   {sel1_2, sel2_2}, acc2, ovf2, halted2, t.sel, t.acc, t.ovf, t.halted);
        end
      end else begin
        if (tq.size() != 0) begin
          t = tq.pop_front();
          n_checks++;
          if ({sel1_4, sel2_4, acc4, ovf4, halted4} !== {t.sel, t.acc, t.ovf, t.halted}) begin
            n_fail++;
            $display("FAIL trace_w4 edge %0d: got sel=%0d acc=%0d ovf=%b halted=%b, expected sel=%0d acc=%0d ovf=%b halted=%b",
                     edge_cnt, {sel1_4, sel2_4}, acc4, ovf4, halted4, t.sel, t.acc, t.ovf, t.halted);
          end
        end
        if (halted4 && !h4_prev) begin
          n_checks++;
          if (hq4.size() == 0) begin
            n_fail++;
            $display("FAIL halt_w4: got halt at edge %0d, expected no halt", edge_cnt);
          end else begin
            h = hq4.pop_front();
            if (edge_cnt != h.edge_no || acc4 !== h.acc || ovf4 !== h.ovf) begin
              n_fail++;
              $display("FAIL halt_w4: got edge %0d acc=%0d ovf=%b, expected edge %0d acc=%0d ovf=%b",
                       edge_cnt, acc4, ovf4, h.edge_no, h.acc, h.ovf);
            end
          end
        end else if (hq4.size() != 0 && edge_cnt >= hq4[0].edge_no) begin
          h = hq4.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL halt_w4: got halted=%b at edge %0d, expected halt at edge %0d",
                   halted4, edge_cnt, h.edge_no);
        end
        if (halted2 && !h2_prev) begin
          n_checks++;
          if (hq2.size() == 0) begin
            n_fail++;
            $display("FAIL halt_w2: got halt at edge %0d, expected no halt", edge_cnt);
          end else begin
            h = hq2.pop_front();
            if (edge_cnt != h.edge_no || {2'b00, acc2} !== h.acc || ovf2 !== h.ovf) begin
              n_fail++;
              $display("FAIL halt_w2: got edge %0d acc=%0d ovf=%b, expected edge %0d acc=%0d ovf=%b",
                       edge_cnt, acc2, ovf2, h.edge_no, h.acc, h.ovf);
            end
          end
        end else if (hq2.size() != 0 && edge_cnt >= hq2[0].edge_no) begin
          h = hq2.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL halt_w2: got halted=%b at edge %0d, expected halt at edge %0d",
                   halted2, edge_cnt, h.edge_no);
        end
        h4_prev = halted4;
        h2_prev = halted2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // prog = {word3, word2, word1, word0}; returns 2 units after edge 0.
  task automatic load(input logic [7:0] prog);
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) rom[i] = prog[2*i +: 2];
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n) begin
      tick();
      guard++;
      if (guard > 1000) begin
        $display("FAIL run_to: got edge %0d, expected to reach edge %0d", edge_cnt, n);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((hq4.size() != 0 || hq2.size() != 0 || tq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (hq4.size() != 0 || hq2.size() != 0 || tq.size() != 0) begin
      $display("FAIL wait_idle: got %0d pending expectations, expected 0",
               hq4.size() + hq2.size() + tq.size());
      $fatal(1);
    end
  endtask

  task automatic exp_tr(input logic [1:0] sel, input logic [3:0] a, input logic o,
                        input logic h);
    trace_t t;
    t.sel = sel; t.acc = a; t.ovf = o; t.halted = h;
    tq.push_back(t);
  endtask

  task automatic exp_halt(input int e4, input logic [3:0] a4, input logic o4,
                          input int e2, input logic [3:0] a2, input logic o2);
    halt_t h;
    h.edge_no = e4; h.acc = a4; h.ovf = o4;
    hq4.push_back(h);
    h.edge_no = e2; h.acc = a2; h.ovf = o2;
    hq2.push_back(h);
  endtask

  initial begin : stimulus
    trace_t s;
    logic [7:0] prog_a;
    int sel_nop [10];
    int sel_lit [8];
    int sel_wrap [13];
    prog_a   = {OP_HLT, OP_INC, OP_JNO, OP_INC};
    sel_nop  = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    sel_lit  = '{0, 1, 1, 0, 1, 1, 0, 1};
    sel_wrap = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 3, 0, 0, 3};

    // Loop program: 5-cycle body, halt on edge 82 (width 4) and 22 (width 2).
    load(prog_a);
    exp_halt(82, 4'd0, 1'b1, 22, 4'd0, 1'b1);
    exp_tr(2'd0, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd2, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd2, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd0, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd2, 1'b0, 1'b0);
    exp_tr(2'd2, 4'd2, 1'b0, 1'b0);
    exp_tr(2'd2, 4'd2, 1'b0, 1'b0);
    exp_tr(2'd0, 4'd2, 1'b0, 1'b0);
    run_to(75);
    exp_tr(2'd0, 4'd15, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd15, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd0, 1'b1, 1'b0);
    exp_tr(2'd2, 4'd0, 1'b1, 1'b0);
    exp_tr(2'd2, 4'd0, 1'b1, 1'b0);
    exp_tr(2'd3, 4'd0, 1'b1, 1'b0);
    exp_tr(2'd0, 4'd0, 1'b1, 1'b0);
    exp_tr(2'd0, 4'd0, 1'b1, 1'b1);
    exp_tr(2'd0, 4'd0, 1'b1, 1'b1);
    wait_idle(200);

    // en low for 3 cycles while in the first OPERAND: everything slips 3 edges.
    load(prog_a);
    exp_halt(85, 4'd0, 1'b1, 25, 4'd0, 1'b1);
    run_to(4);
    en = 1'b0;
    for (int i = 0; i < 4; i++) exp_tr(2'd2, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd0, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd2, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    en = 1'b1;
    wait_idle(200);

    // Asynchronous reset during EXEC of the 7th INC.
    load(prog_a);
    hq2.push_back('{22, 4'd0, 1'b1});
    run_to(30);
    exp_tr(2'd0, 4'd6, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd6, 1'b0, 1'b0);
    tick();
    #4;
    reset = 1'b1;
    #1;
    s.sel = 2'd0; s.acc = 4'd0; s.ovf = 1'b0; s.halted = 1'b0;
    sq.push_back(s);
    ->snap_ev;
    tick();
    reset = 1'b0;
    exp_halt(82, 4'd0, 1'b1, 22, 4'd0, 1'b1);
    wait_idle(200);

    // All reserved opcodes: pc steps every 2 cycles, nothing else changes.
    load({2'b11, 2'b11, 2'b11, 2'b11});
    foreach (sel_nop[i]) exp_tr(2'(sel_nop[i]), 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick();

    // Word 1 doubles as the JNO operand (00): jump back to 0, never halts.
    load({OP_JNO, OP_HLT, OP_INC, OP_JNO});
    foreach (sel_lit[i]) exp_tr(2'(sel_lit[i]), 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick();

    // Taken JNO to address 2, then INC and HLT: halted on edge 7.
    load({OP_HLT, OP_INC, 2'b10, OP_JNO});
    exp_halt(7, 4'd1, 1'b0, 7, 4'd1, 1'b0);
    exp_tr(2'd0, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd1, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd2, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd3, 4'd0, 1'b0, 1'b0);
    exp_tr(2'd3, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd0, 4'd1, 1'b0, 1'b0);
    exp_tr(2'd0, 4'd1, 1'b0, 1'b1);
    exp_tr(2'd0, 4'd1, 1'b0, 1'b1);
    wait_idle(50);

    // JNO at address 3 reads its operand (3) from address 0.
    load({OP_JNO, 2'b11, 2'b11, 2'b11});
    foreach (sel_wrap[i]) exp_tr(2'(sel_wrap[i]), 4'd0, 1'b0, 1'b0);
    wait_idle(50);
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
